bcd_display_ctrl: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 38 +++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/bcd_display_ctrl.sv | 116 +++++++++++
 tb/tb_bcd_display_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD conversion / seven-segment display block.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned ITER    = 16;
  localparam int unsigned MAX_BCD = 9999;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction step: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] add3_all(input logic [15:0] acc);
    logic [15:0] res;
    res = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low seven-segment decoder with a blank override.
// Non-decimal nibbles decode to blank.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential 16-bit binary-to-BCD converter (one double-dabble iteration per clock)
// feeding a 4-digit multiplexed seven-segment display scanner.
module bcd_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_bin,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  state_t      state;
  logic [15:0] sr;
  logic [15:0] acc;
  logic [15:0] acc_adj;
  logic [3:0]  iter;
  logic        ovf_next;
  logic [15:0] disp;
  logic [15:0] operand;
  logic        accept;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    zero_run;
  logic [3:0]    nibble;
  logic          digit_blank;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign operand  = (in_bin > 16'(MAX_BCD)) ? 16'(MAX_BCD) : in_bin;
  assign acc_adj  = add3_all(acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      iter      <= '0;
      ovf_next  <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      ovf       <= 1'b0;
      disp      <= '0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr       <= operand;
            acc      <= '0;
            iter     <= '0;
            ovf_next <= (in_bin > 16'(MAX_BCD));
            state    <= CONV;
          end
        end
        CONV: begin
          {acc, sr} <= {acc_adj, sr} << 1;
          iter      <= iter + 4'd1;
          if (iter == 4'(ITER - 1))
            state <= DONE;
        end
        DONE: begin
          bcd_out   <= acc;
          ovf       <= ovf_next;
          disp      <= acc;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // zero_run[i]: digit i and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    zero_run[3] = (disp[15:12] == 4'd0);
    zero_run[2] = zero_run[3] && (disp[11:8] == 4'd0);
    zero_run[1] = zero_run[2] && (disp[7:4] == 4'd0);
    zero_run[0] = 1'b0;
  end

  assign nibble      = disp[idx*4 +: 4];
  assign digit_blank = (BLANK_LZ != 0) && zero_run[idx];
  assign an          = ~(4'b0001 << idx);

  bcd_to_seg7 u_dec (
    .digit (nibble),
    .blank (digit_blank),
    .seg   (seg)
  );

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: randomized operands against a decimal
// arithmetic model, plus directed handshake, scan, blanking and reset scenarios.
module tb_bcd_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bin;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  bcd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .ovf       (ovf),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Leading zeros are digits above the most significant nonzero one.
  function automatic logic [6:0] exp_seg(input int val, input int pos);
    if (pos != 0 && val < pow10(pos)) return 7'b1111111;
    return digit_seg((val / pow10(pos)) % 10);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 60) begin
      step();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: in_ready=%b required 1 within 60 cycles", in_ready);
    end
  endtask

  task automatic accept(input int v);
    wait_ready();
    in_valid = 1'b1;
    in_bin   = 16'(v);
    step();
    in_valid = 1'b0;
    in_bin   = 16'hxxxx;
  endtask

  task automatic check_display(input int val);
    for (int k = 0; k < 20; k++) begin
      int pos = -1;
      step();
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) pos = i;
      total++;
      if (pos < 0) begin
        bad++;
        $display("FAIL display_an: an=%b required one-hot-low", an);
      end else begin
        total++;
        if (seg !== exp_seg(val, pos)) begin
          bad++;
          $display("FAIL display_seg val=%0d digit=%0d: seg=%b required %b",
                   val, pos, seg, exp_seg(val, pos));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bin = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || bcd_out !== 16'h0000 || bcd_valid !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b bcd=%h valid=%b ovf=%b required 1 0000 0 0",
               in_ready, bcd_out, bcd_valid, ovf);
    end
  endtask

  task automatic test_scan();
    // Bench sits 1 time unit after the reset edge: counter and digit index both 0.
    for (int k = 0; k < 17; k++) begin
      int pos = (k / 4) % 4;
      logic [3:0] ea;
      logic [6:0] es;
      ea = ~(4'b0001 << pos);
      es = (pos == 0) ? 7'b1000000 : 7'b1111111;
      total++;
      if (an !== ea || seg !== es) begin
        bad++;
        $display("FAIL scan k=%0d: an=%b seg=%b required %b %b", k, an, seg, ea, es);
      end
      step();
    end
  endtask

  task automatic test_convert(input int v);
    int pulses = 0;
    accept(v);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bcd_valid === 1'b1) pulses++;
      total++;
      if (bcd_valid !== (k == 17)) begin
        bad++;
        $display("FAIL conv_valid v=%0d k=%0d: bcd_valid=%b required %b", v, k, bcd_valid, k == 17);
      end
      if (k <= 16) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL conv_ready v=%0d k=%0d: in_ready=%b required 0", v, k, in_ready);
        end
      end
      if (k == 17) begin
        total++;
        if (bcd_out !== to_bcd(sat(v)) || ovf !== (v > 9999) || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL conv_result v=%0d: bcd=%h ovf=%b ready=%b required %h %b 1",
                   v, bcd_out, ovf, in_ready, to_bcd(sat(v)), v > 9999);
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL conv_pulses v=%0d: pulses=%0d required 1", v, pulses);
    end
    total++;
    if (bcd_out !== to_bcd(sat(v)) || ovf !== (v > 9999)) begin
      bad++;
      $display("FAIL conv_hold v=%0d: bcd=%h ovf=%b required %h %b",
               v, bcd_out, ovf, to_bcd(sat(v)), v > 9999);
    end
    check_display(sat(v));
  endtask

  task automatic test_back_to_back();
    wait_ready();
    in_valid = 1'b1;
    in_bin   = 16'd5;
    step();
    in_bin   = 16'd42;
    for (int k = 1; k <= 17; k++) begin
      step();
      total++;
      if (in_ready !== (k == 17)) begin
        bad++;
        $display("FAIL b2b_ready k=%0d: in_ready=%b required %b", k, in_ready, k == 17);
      end
    end
    total++;
    if (bcd_valid !== 1'b1 || bcd_out !== 16'h0005) begin
      bad++;
      $display("FAIL b2b_first: valid=%b bcd=%h required 1 0005", bcd_valid, bcd_out);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_accept: in_ready=%b required 0", in_ready);
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      total++;
      if (bcd_valid !== (k == 17)) begin
        bad++;
        $display("FAIL b2b_second_valid k=%0d: bcd_valid=%b required %b", k, bcd_valid, k == 17);
      end
    end
    total++;
    if (bcd_out !== 16'h0042 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: bcd=%h ovf=%b required 0042 0", bcd_out, ovf);
    end
  endtask

  task automatic test_reset_mid_conv();
    int pulses = 0;
    accept(9876);
    for (int k = 1; k < 8; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || bcd_out !== 16'h0000 || ovf !== 1'b0 || bcd_valid !== 1'b0 ||
        an !== 4'b1110 || seg !== 7'b1000000) begin
      bad++;
      $display("FAIL midreset_state: ready=%b bcd=%h ovf=%b valid=%b an=%b seg=%b required 1 0000 0 0 1110 1000000",
               in_ready, bcd_out, ovf, bcd_valid, an, seg);
    end
    for (int k = 0; k < 25; k++) begin
      step();
      if (bcd_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || bcd_out !== 16'h0000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_quiet: pulses=%0d bcd=%h ready=%b required 0 0000 1",
               pulses, bcd_out, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9999));
      test_convert(v);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert(1234);
    test_convert(65535);
    test_convert(7);
    test_back_to_back();
    test_convert(9999);
    test_convert(10000);
    test_reset_mid_conv();
    test_convert(0);
    test_convert(1004);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
